// File: rtl/axi_bti2_pkg.sv
// rtl/axi_bti2_pkg.sv - shared constants and FSM state types for the BTI2 AXI4-Lite slave
package axi_bti2_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         DATA_WIDTH = 32;
    localparam int         STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COLLECT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_bti2_lite_slave_if.sv
// rtl/axi_bti2_lite_slave_if.sv - S00_AXI AXI4-Lite bus bundle with master/slave views
interface axi_bti2_lite_slave_if #(
    parameter int ADDR_WIDTH = 4
);
    import axi_bti2_pkg::*;

    logic [ADDR_WIDTH-1:0] s_axi_awaddr;
    logic [2:0]            s_axi_awprot;
    logic                  s_axi_awvalid;
    logic                  s_axi_awready;
    logic [DATA_WIDTH-1:0] s_axi_wdata;
    logic [STRB_WIDTH-1:0] s_axi_wstrb;
    logic                  s_axi_wvalid;
    logic                  s_axi_wready;
    logic [1:0]            s_axi_bresp;
    logic                  s_axi_bvalid;
    logic                  s_axi_bready;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic [2:0]            s_axi_arprot;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output s_axi_rready
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  s_axi_rready
    );

endinterface

// File: rtl/axi_bti2_strb_merge.sv
// rtl/axi_bti2_strb_merge.sv - byte-lane merge of new write data into an existing register value
module axi_bti2_strb_merge
    import axi_bti2_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_WIDTH-1:0] strb_i,
    output logic [DATA_WIDTH-1:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (strb_i[k]) begin
                merged_o[8*k +: 8] = wdata_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/axi_bti2_lite_slave.sv
// rtl/axi_bti2_lite_slave.sv - AXI4-Lite register file for the BTI2 sensor control registers
module axi_bti2_lite_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    axi_bti2_lite_slave_if.slave           s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            reg_wr_o
);
    import axi_bti2_pkg::*;

    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_t             wr_state_q, wr_state_d;
    rd_state_t             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [NUM_REGS-1:0]   reg_wr_q, reg_wr_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data, merged;
    logic [STRB_WIDTH-1:0] wr_strb;
    logic                  unused_bits;

    assign aw_hs  = s_axi.s_axi_awvalid && awready_q;
    assign w_hs   = s_axi.s_axi_wvalid && wready_q;
    assign ar_hs  = s_axi.s_axi_arvalid && arready_q;
    assign commit = (wr_state_q != WR_RESP) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // A held beat wins over the live bus; the live one only matters in its handshake cycle.
    assign wr_idx  = aw_held_q ? aw_idx_q : s_axi.s_axi_awaddr[ADDR_WIDTH-1:2];
    assign wr_data = w_held_q ? wdata_q : s_axi.s_axi_wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axi.s_axi_wstrb;

    axi_bti2_strb_merge u_merge (
        .old_i    (regs_q[wr_idx]),
        .wdata_i  (wr_data),
        .strb_i   (wr_strb),
        .merged_o (merged)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        regs_d     = regs_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        reg_wr_d   = '0;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.s_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.s_axi_wdata;
            wstrb_d  = s_axi.s_axi_wstrb;
        end
        case (wr_state_q)
            WR_IDLE, WR_COLLECT: begin
                if (commit) begin
                    wr_state_d     = WR_RESP;
                    aw_held_d      = 1'b0;
                    w_held_d       = 1'b0;
                    regs_d[wr_idx] = merged;
                    reg_wr_d       = NUM_REGS'(1) << wr_idx;
                end else if (aw_held_d || w_held_d) begin
                    wr_state_d = WR_COLLECT;
                end else begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_RESP: begin
                if (s_axi.s_axi_bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
        bvalid_d  = (wr_state_d == WR_RESP);
        awready_d = !aw_held_d && (wr_state_d != WR_RESP);
        wready_d  = !w_held_d && (wr_state_d != WR_RESP);
    end

    // Reads sample regs_q, so a same-cycle commit is seen only by later reads.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = regs_q[s_axi.s_axi_araddr[ADDR_WIDTH-1:2]];
                end
            end
            RD_DATA: begin
                if (s_axi.s_axi_rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
        rvalid_d  = (rd_state_d == RD_DATA);
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            reg_wr_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            regs_q     <= regs_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            reg_wr_q   <= reg_wr_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign reg_wr_o            = reg_wr_q;
    assign s_axi.s_axi_awready = awready_q;
    assign s_axi.s_axi_wready  = wready_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = RESP_OKAY;
    assign s_axi.s_axi_arready = arready_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = RESP_OKAY;

    assign unused_bits = ^{s_axi.s_axi_awprot, s_axi.s_axi_arprot,
                           s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_bti2_lite_slave.sv
// tb/tb_axi_bti2_lite_slave.sv - randomized self-checking bench for axi_bti2_lite_slave
module tb_axi_bti2_lite_slave;

    logic         clock;
    logic         reset;
    logic [127:0] regs_o;
    logic [3:0]   reg_wr_o;
    logic [31:0]  model [4];
    int           checks;
    int           errors;

    axi_bti2_lite_slave_if #(.ADDR_WIDTH(4)) bus ();

    axi_bti2_lite_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .NUM_REGS   (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .s_axi    (bus),
        .regs_o   (regs_o),
        .reg_wr_o (reg_wr_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    task automatic idle_bus();
        bus.s_axi_awaddr = '0; bus.s_axi_awprot = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0;  bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arprot = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready = 1'b0;
    endtask

    // Inputs change and outputs are sampled at negedge, half a cycle away from the active edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, input bit pend_aw);
        int cyc;
        int idx;
        bit aw_done, w_done, aw_fire, w_fire;
        idx = int'(addr[3:2]);
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clock);
            check("early_bvalid", 32'(bus.s_axi_bvalid), 0);
            bus.s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_axi_awaddr  = addr;
            bus.s_axi_awprot  = 3'($urandom);
            bus.s_axi_wvalid  = !w_done && (cyc >= w_dly);
            bus.s_axi_wdata   = data;
            bus.s_axi_wstrb   = strb;
            aw_fire = bus.s_axi_awvalid && bus.s_axi_awready;
            w_fire  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clock);
            aw_done = aw_done || aw_fire;
            w_done  = w_done || w_fire;
            cyc++;
        end
        if (!(aw_done && w_done)) check("wr_handshake_timeout", 0, 1);
        @(negedge clock);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        model[idx] = (model[idx] & ~strb_mask(strb)) | (data & strb_mask(strb));
        check("bvalid", 32'(bus.s_axi_bvalid), 1);
        check("bresp", 32'(bus.s_axi_bresp), 0);
        check("reg_wr_pulse", 32'(reg_wr_o), 32'(1) << idx);
        check("regs_o_after_wr", regs_o[32*idx +: 32], model[idx]);
        for (int i = 0; i < b_dly; i++) begin
            bus.s_axi_awvalid = pend_aw;
            bus.s_axi_awaddr  = addr ^ 4'h4;
            @(negedge clock);
            check("bvalid_hold", 32'(bus.s_axi_bvalid), 1);
            check("awready_blocked", 32'(bus.s_axi_awready), 0);
            check("wready_blocked", 32'(bus.s_axi_wready), 0);
            check("reg_wr_single", 32'(reg_wr_o), 0);
        end
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_bready  = 1'b1;
        @(negedge clock);
        bus.s_axi_bready = 1'b0;
        check("bvalid_clear", 32'(bus.s_axi_bvalid), 0);
        check("awready_back", 32'(bus.s_axi_awready), 1);
        check("wready_back", 32'(bus.s_axi_wready), 1);
        check("reg_wr_clear", 32'(reg_wr_o), 0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly);
        int cyc;
        bit fire;
        logic [31:0] exp;
        exp = model[addr[3:2]];
        cyc = 0; fire = 0;
        while (!fire && cyc < 40) begin
            @(negedge clock);
            bus.s_axi_arvalid = 1'b1;
            bus.s_axi_araddr  = addr;
            bus.s_axi_arprot  = 3'($urandom);
            fire = bus.s_axi_arready;
            @(posedge clock);
            cyc++;
        end
        if (!fire) check("rd_handshake_timeout", 0, 1);
        @(negedge clock);
        bus.s_axi_arvalid = 1'b0;
        check("rvalid", 32'(bus.s_axi_rvalid), 1);
        check("rdata", bus.s_axi_rdata, exp);
        check("rresp", 32'(bus.s_axi_rresp), 0);
        check("arready_busy", 32'(bus.s_axi_arready), 0);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clock);
            check("rvalid_hold", 32'(bus.s_axi_rvalid), 1);
            check("rdata_hold", bus.s_axi_rdata, exp);
        end
        bus.s_axi_rready = 1'b1;
        @(negedge clock);
        bus.s_axi_rready = 1'b0;
        check("rvalid_clear", 32'(bus.s_axi_rvalid), 0);
        check("arready_back", 32'(bus.s_axi_arready), 1);
        check("rdata_kept", bus.s_axi_rdata, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 4; i++) model[i] = '0;
        idle_bus();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_awready", 32'(bus.s_axi_awready), 0);
        check("rst_wready", 32'(bus.s_axi_wready), 0);
        check("rst_arready", 32'(bus.s_axi_arready), 0);
        check("rst_bvalid", 32'(bus.s_axi_bvalid), 0);
        check("rst_rvalid", 32'(bus.s_axi_rvalid), 0);
        check("rst_rdata", bus.s_axi_rdata, 0);
        check("rst_reg_wr", 32'(reg_wr_o), 0);
        for (int i = 0; i < 4; i++) check("rst_regs_o", regs_o[32*i +: 32], 0);
        reset = 1'b0;
        @(negedge clock);
        check("rel_awready", 32'(bus.s_axi_awready), 1);
        check("rel_wready", 32'(bus.s_axi_wready), 1);
        check("rel_arready", 32'(bus.s_axi_arready), 1);

        for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(4 * i), 0);

        axi_write(4'h4, 32'hAABBCCDD, 4'hF, 0, 0, 1, 0);
        axi_write(4'h4, 32'h11223344, 4'b0101, 1, 0, 0, 0);
        axi_read(4'h4, 1);
        check("strb_merge_value", model[1], 32'hAA22CC44);

        axi_write(4'h8, 32'h5A5A5A5A, 4'hF, 3, 0, 0, 0);
        axi_read(4'h8, 0);

        axi_write(4'h0, 32'hCAFE0001, 4'hF, 0, 0, 5, 1);
        axi_write(4'h4, 32'h0BAD0002, 4'hF, 0, 2, 0, 0);

        // AR and write commit to 0xC in the same cycle.
        @(negedge clock);
        check("sim_ready", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 7);
        bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 4'hC;
        bus.s_axi_wvalid = 1'b1;  bus.s_axi_wdata = 32'h99; bus.s_axi_wstrb = 4'hF;
        bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = 4'hC;
        @(negedge clock);
        idle_bus();
        check("sim_rdata_old", bus.s_axi_rdata, 32'h4);
        check("sim_bvalid", 32'(bus.s_axi_bvalid), 1);
        check("sim_rvalid", 32'(bus.s_axi_rvalid), 1);
        check("sim_reg_wr", 32'(reg_wr_o), 32'h8);
        model[3] = 32'h99;
        bus.s_axi_bready = 1'b1; bus.s_axi_rready = 1'b1;
        @(negedge clock);
        idle_bus();
        axi_read(4'hC, 0);

        // Reset while AW is held (W never sent) and a read response is pending.
        @(negedge clock);
        bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 4'h4;
        bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = 4'h0;
        @(negedge clock);
        idle_bus();
        check("pre_rst_rvalid", 32'(bus.s_axi_rvalid), 1);
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 4; i++) model[i] = '0;
        check("mid_rst_bvalid", 32'(bus.s_axi_bvalid), 0);
        check("mid_rst_rvalid", 32'(bus.s_axi_rvalid), 0);
        check("mid_rst_awready", 32'(bus.s_axi_awready), 0);
        check("mid_rst_reg_wr", 32'(reg_wr_o), 0);
        for (int i = 0; i < 4; i++) check("mid_rst_regs_o", regs_o[32*i +: 32], 0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 7);
        axi_write(4'h8, 32'h13572468, 4'hF, 3, 0, 0, 0);
        axi_read(4'h4, 0);
        axi_read(4'h8, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] a;
            a = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), 0);
            else
                axi_read(a, $urandom_range(0, 2));
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(4 * i), 0);
            check("final_regs_o", regs_o[32*i +: 32], model[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bti2_lite_slave.md
# axi_bti2_lite_slave

AXI4-Lite slave register file for the BTI2 reliability-sensor IP. It is the responder end of the S00_AXI bus: it accepts single-beat writes and reads from the AXI master (VIP or PS) and holds the sensor control registers. It also exports the register contents and per-register write pulses to the sensor core. Register 0 sits at byte offset 0x0, and each following register is 4 bytes higher.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 supported.
- ADDR_WIDTH, 4, AXI address width; must satisfy 2^(ADDR_WIDTH-2) = NUM_REGS.
- NUM_REGS, 4, number of 32-bit read/write registers.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_axi_awaddr / s_axi_awprot / s_axi_awvalid  in  ADDR_WIDTH / 3 / 1  write address channel; prot ignored.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata / s_axi_wstrb / s_axi_wvalid  in  32 / 4 / 1  write data channel.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp / s_axi_bvalid  out  2 / 1  write response; bresp always 2'b00 (OKAY).
- s_axi_bready  in  1  write response ready.
- s_axi_araddr / s_axi_arprot / s_axi_arvalid  in  ADDR_WIDTH / 3 / 1  read address channel; prot ignored.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata / s_axi_rresp / s_axi_rvalid  out  32 / 2 / 1  read data channel; rresp always 2'b00.
- s_axi_rready  in  1  read data ready.
- regs_o  out  NUM_REGS*32  register contents, reg i at bits [32*i+31:32*i].
- reg_wr_o  out  NUM_REGS  one-cycle pulse on the cycle after reg i is written.

## Operation
- Register index = addr[ADDR_WIDTH-1:2]. Address bits [1:0] are ignored. There are no out-of-range addresses.
- Write path, states IDLE / COLLECT / RESP:
  - AW and W are captured independently, in either order, into holding flops aw_held and w_held.
  - awready = !aw_held && !bvalid, registered.
  - wready = !w_held && !bvalid, registered.
  - Commit happens when both address and data are available, either held or handshaking this cycle.
  - On commit, each byte lane k with wstrb[k]=1 updates reg[idx][8k+7:8k]. Other bytes keep their value.
  - Commit clears aw_held/w_held, sets bvalid, and pulses reg_wr_o[idx].
  - RESP: bvalid stays high until s_axi_bready; the FSM then returns to IDLE.
- Only one write is outstanding. No AW/W is accepted while bvalid=1.
- Read path, states IDLE / DATA:
  - arready = !rvalid.
  - On the AR handshake, rdata <= reg[idx] and rvalid <= 1 on the next edge.
  - rdata and rvalid are held stable until s_axi_rready.
- Simultaneous events:
  - A read and a write commit to the same register in one cycle: the read returns the pre-write value.
  - Read and write paths are fully independent.
- rdata holds its last value when rvalid=0.

## Timing
- Reset values: all registers 0, regs_o=0, reg_wr_o=0, all valid and ready outputs 0, rdata=0, bresp/rresp=0.
- awready, wready and arready go to 1 on the first edge after reset deasserts.
- Reset asserted mid-transaction: held AW/W are discarded, and pending bvalid/rvalid drop on the next edge. No partial write occurs unless commit happened before the reset edge.
- Write latency:
  - AW and W handshake in cycle N: registers update at the N+1 edge; bvalid and reg_wr_o are high in cycle N+1.
  - W arriving M cycles after AW: commit happens in the W handshake cycle.
- Read latency: AR handshake in cycle N → rvalid=1 with data in cycle N+1.
- Throughput: with bready and rready tied high, one write every 2 cycles and one read every 2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package axi_bti2_pkg holds:
  - localparams RESP_OKAY=2'b00, DATA_WIDTH=32, STRB_WIDTH=4.
  - enum wr_state_t {WR_IDLE, WR_COLLECT, WR_RESP}.
  - enum rd_state_t {RD_IDLE, RD_DATA}.
- One sub-module: axi_bti2_strb_merge (combinational byte-lane merge of old value, wdata and wstrb). It is instantiated once on the selected register.
- The register array, write FSM and read FSM live in the top module.

## Test plan
- Sequential writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with wstrb=4'hF, then reads back → rdata 0x1, 0x2, 0x3, 0x4, all resp OKAY, reg_wr_o pulses 0001, 0010, 0100, 1000.
- Write 0xAABBCCDD to 0x4, then write 0x11223344 with wstrb=4'b0101 → read of 0x4 returns 0xAA22CC44.
- W valid 3 cycles before AW to 0x8 with data 0x5A5A5A5A → wready handshake first, commit on the AW cycle, bvalid next cycle, read returns 0x5A5A5A5A.
- bready held low 5 cycles after a write → bvalid stays 1, awready/wready stay 0, and a second AW stays unaccepted until bready is high.
- Same-cycle AR and commit on 0xC (old 0x4, new 0x99) → rdata=0x4; a following read returns 0x99.
- Reset asserted while AW is held and W is pending → no register change, all valids 0 after the reset edge, readies 1 on the first cycle after reset release.
